// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a scanned 6-digit 7-segment display: filters the
// scanned lines for stability, decodes each digit and publishes whole frames.
`timescale 1ns/1ps
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 4,
  parameter bit ENB_ACT_LOW = 1'b0,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  i_seg_enb,
  input  logic        i_seg_dp,
  input  logic [6:0]  i_seg,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic        o_frame_vld,
  output logic        o_seg_err,
  output logic        o_scan_err,
  output logic        o_synced
);

  localparam int            CW      = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

  localparam logic [0:0] SYNC    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  function automatic logic [3:0] decode(input logic [6:0] pat);
    case (pat)
      7'h7E:   decode = 4'h0;
      7'h30:   decode = 4'h1;
      7'h6D:   decode = 4'h2;
      7'h79:   decode = 4'h3;
      7'h33:   decode = 4'h4;
      7'h5B:   decode = 4'h5;
      7'h5F:   decode = 4'h6;
      7'h70:   decode = 4'h7;
      7'h7F:   decode = 4'h8;
      7'h7B:   decode = 4'h9;
      default: decode = 4'hF;
    endcase
  endfunction

  // Input register (in_*) and the previous sample (pv_*); the valid bits make
  // the first post-reset sample count as a change.
  logic [5:0]    in_enb, pv_enb;
  logic [6:0]    in_seg, pv_seg;
  logic          in_dp, pv_dp;
  logic          in_vld, pv_vld;
  logic [CW-1:0] cnt;
  logic          captured;
  logic          chg, capture;

  // NOTE: all sequential state below uses non-blocking assignment so every
  // register in the pipeline sees the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_enb   <= '0;
      in_seg   <= '0;
      in_dp    <= 1'b0;
      in_vld   <= 1'b0;
      pv_enb   <= '0;
      pv_seg   <= '0;
      pv_dp    <= 1'b0;
      pv_vld   <= 1'b0;
      cnt      <= '0;
      captured <= 1'b0;
    end else begin
      in_enb   <= ENB_ACT_LOW ? ~i_seg_enb : i_seg_enb;
      in_seg   <= SEG_ACT_LOW ? ~i_seg : i_seg;
      in_dp    <= SEG_ACT_LOW ? ~i_seg_dp : i_seg_dp;
      in_vld   <= 1'b1;
      pv_enb   <= in_enb;
      pv_seg   <= in_seg;
      pv_dp    <= in_dp;
      pv_vld   <= in_vld;
      if (chg) begin
        cnt      <= '0;
        captured <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
        if (capture) captured <= 1'b1;
      end
    end
  end

  assign chg     = !pv_vld || ({in_enb, in_seg, in_dp} != {pv_enb, pv_seg, pv_dp});
  assign capture = pv_vld && (cnt == CNT_MAX) && !captured;

  // Classification of the captured sample (held in pv_*).
  logic [2:0] k;
  logic       blank, multi, bad;
  logic [3:0] dig;

  always_comb begin
    k = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (pv_enb[i]) k = 3'(i);
    end
  end

  assign blank = (pv_enb == 6'd0);
  assign multi = ((pv_enb & (pv_enb - 6'd1)) != 6'd0);
  assign dig   = decode(pv_seg);
  assign bad   = (dig == 4'hF);

  logic [0:0]  state;
  logic [2:0]  exp_idx;
  logic [23:0] shadow;
  logic [5:0]  shadow_dp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SYNC;
      exp_idx     <= 3'd0;
      shadow      <= '1;
      shadow_dp   <= '0;
      o_digits    <= '1;
      o_dp        <= '0;
      o_frame_vld <= 1'b0;
      o_seg_err   <= 1'b0;
      o_scan_err  <= 1'b0;
    end else begin
      o_frame_vld <= 1'b0;
      o_seg_err   <= 1'b0;
      o_scan_err  <= 1'b0;
      if (capture && !blank) begin
        if (multi) begin
          o_scan_err <= 1'b1;
          state      <= SYNC;
          shadow     <= '1;
          shadow_dp  <= '0;
        end else if (state == SYNC) begin
          if (k == 3'd0) begin
            shadow[3:0]  <= dig;
            shadow_dp[0] <= pv_dp;
            o_seg_err    <= bad;
            exp_idx      <= 3'd1;
            state        <= COLLECT;
          end
        end else if (k == exp_idx) begin
          shadow[{k, 2'b00} +: 4] <= dig;
          shadow_dp[k]            <= pv_dp;
          o_seg_err               <= bad;
          if (k == 3'd5) begin
            // Last digit goes straight to the output alongside the stored five.
            o_digits    <= {dig, shadow[19:0]};
            o_dp        <= {pv_dp, shadow_dp[4:0]};
            o_frame_vld <= 1'b1;
            exp_idx     <= 3'd0;
          end else begin
            exp_idx <= exp_idx + 3'd1;
          end
        end else begin
          o_scan_err <= 1'b1;
          o_seg_err  <= bad;
          state      <= SYNC;
          shadow     <= '1;
          shadow_dp  <= '0;
        end
      end
    end
  end

  assign o_synced = (state == COLLECT);

endmodule
